// File: rtl/dcim_bitserial_ctrl.sv
// Bit-serial drive controller for the DCIM shift-accumulator: accepts one activation
// vector, clears the accumulator, streams MSB-first bit planes, then captures the result.
module dcim_bitserial_ctrl #(
  parameter int ROWS      = 64,
  parameter int IN_BITS   = 8,
  parameter int ACC_W     = 51,
  parameter int ARRAY_LAT = 0
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ROWS*IN_BITS-1:0] in_data,
  output logic [ROWS-1:0]         wl_bit,
  output logic                    wl_en,
  output logic                    st,
  output logic                    acm_en,
  input  logic [ACC_W-1:0]        acc_nout,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_data,
  output logic                    busy
);

  localparam int CNT_MAX = (IN_BITS > ARRAY_LAT) ? IN_BITS : ARRAY_LAT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] LAST_PLANE = CW'(IN_BITS - 1);
  localparam logic [CW-1:0] LAST_DRAIN = CW'((ARRAY_LAT > 0) ? ARRAY_LAT - 1 : 0);

  typedef enum logic [2:0] {IDLE, CLR, STREAM, DRAIN, CAPTURE} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [ROWS*IN_BITS-1:0] shreg;
  logic [ROWS*IN_BITS-1:0] shreg_next;
  logic [ROWS-1:0]         plane;

  // Each row's activation sits in its own IN_BITS lane; the lane MSB is the next plane bit.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign plane[r] = shreg[r*IN_BITS + IN_BITS - 1];
    assign shreg_next[r*IN_BITS +: IN_BITS] = {shreg[r*IN_BITS +: IN_BITS-1], 1'b0};
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      wl_bit    <= '0;
      wl_en     <= 1'b0;
      st        <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      st <= 1'b0;
      if (out_ready)
        out_valid <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            shreg    <= in_data;
            in_ready <= 1'b0;
            st       <= 1'b1;
            state    <= CLR;
          end
        end
        CLR: begin
          wl_bit <= plane;
          shreg  <= shreg_next;
          wl_en  <= 1'b1;
          cnt    <= '0;
          state  <= STREAM;
        end
        STREAM: begin
          if (cnt == LAST_PLANE) begin
            wl_bit <= '0;
            wl_en  <= 1'b0;
            cnt    <= '0;
            state  <= (ARRAY_LAT == 0) ? CAPTURE : DRAIN;
          end else begin
            wl_bit <= plane;
            shreg  <= shreg_next;
            cnt    <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (cnt == LAST_DRAIN) begin
            cnt   <= '0;
            state <= CAPTURE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CAPTURE: begin
          // A capture on the same edge as a consumer handshake keeps out_valid high.
          if (!out_valid || out_ready) begin
            out_data  <= acc_nout;
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // acm_en trails wl_en by the array pipeline depth so it lines up with partial sums.
  if (ARRAY_LAT == 0) begin : g_no_lat
    assign acm_en = wl_en;
  end else begin : g_lat
    logic [ARRAY_LAT-1:0] dly;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
        dly <= '0;
      else
        dly <= (dly << 1) | ARRAY_LAT'(wl_en);
    end
    assign acm_en = dly[ARRAY_LAT-1];
  end

endmodule

// File: tb/tb_dcim_bitserial_ctrl.sv
// Directed self-checking bench for dcim_bitserial_ctrl with a behavioural array and
// shift-accumulator; one instance with ARRAY_LAT=0 and one with ARRAY_LAT=2.
module tb_dcim_bitserial_ctrl;

  localparam int ROWS    = 64;
  localparam int IN_BITS = 8;
  localparam int ACC_W   = 51;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rstn;
  logic [ROWS*IN_BITS-1:0] in_data;

  logic             in_valid0, in_ready0, wl_en0, st0, acm_en0, out_valid0, out_ready0, busy0;
  logic [ROWS-1:0]  wl_bit0;
  logic [ACC_W-1:0] nout0, out_data0;

  logic             in_valid2, in_ready2, wl_en2, st2, acm_en2, out_valid2, out_ready2, busy2;
  logic [ROWS-1:0]  wl_bit2;
  logic [ACC_W-1:0] nout2, out_data2;

  int               w [ROWS];
  int               total = 0;
  int               bad = 0;
  int               st_count0 = 0;
  int               cyc = 0;
  logic [ACC_W-1:0] res_q [$];
  logic [ACC_W-1:0] a2_d1, a2_d2;

  dcim_bitserial_ctrl #(.ROWS(ROWS), .IN_BITS(IN_BITS), .ACC_W(ACC_W), .ARRAY_LAT(0)) dut0 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data),
    .wl_bit(wl_bit0), .wl_en(wl_en0), .st(st0), .acm_en(acm_en0), .acc_nout(nout0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0), .busy(busy0)
  );

  dcim_bitserial_ctrl #(.ROWS(ROWS), .IN_BITS(IN_BITS), .ACC_W(ACC_W), .ARRAY_LAT(2)) dut2 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data),
    .wl_bit(wl_bit2), .wl_en(wl_en2), .st(st2), .acm_en(acm_en2), .acc_nout(nout2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .busy(busy2)
  );

  function automatic logic [ACC_W-1:0] plane_sum(input logic [ROWS-1:0] p);
    logic [ACC_W-1:0] s = '0;
    for (int r = 0; r < ROWS; r++)
      if (p[r]) s = s + ACC_W'(w[r]);
    return s;
  endfunction

  // Behavioural array + accumulator: zero-latency array for dut0, two-stage array for dut2.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      nout0 <= '0;
      nout2 <= '0;
      a2_d1 <= '0;
      a2_d2 <= '0;
    end else begin
      a2_d1 <= plane_sum(wl_bit2);
      a2_d2 <= a2_d1;
      if (st0)          nout0 <= '0;
      else if (acm_en0) nout0 <= (nout0 << 1) + plane_sum(wl_bit0);
      if (st2)          nout2 <= '0;
      else if (acm_en2) nout2 <= (nout2 << 1) + a2_d2;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Output invariants sampled mid-cycle, plus result and st-pulse logging for dut0.
  always @(negedge clk) begin
    if (rstn) begin
      checkOutput("st_acm_excl0", 64'(st0 && acm_en0), 64'd0);
      checkOutput("wl_zero0", 64'(!wl_en0 && (wl_bit0 != '0)), 64'd0);
      checkOutput("acm_idle0", 64'(acm_en0 && in_ready0), 64'd0);
      checkOutput("st_acm_excl2", 64'(st2 && acm_en2), 64'd0);
      checkOutput("wl_zero2", 64'(!wl_en2 && (wl_bit2 != '0)), 64'd0);
      checkOutput("acm_idle2", 64'(acm_en2 && (in_ready2 || st2 || !busy2)), 64'd0);
      if (st0) st_count0++;
      if (out_valid0 && out_ready0) res_q.push_back(out_data0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready0();
    int g = 0;
    while (!in_ready0 && g < 50) begin
      step();
      g++;
    end
  endtask

  // Hand one vector to dut0 and follow it until out_valid, logging plane bits of row 0.
  task automatic applyStimulus(output int lat, output logic [7:0] seq, output int planes);
    lat    = 0;
    seq    = '0;
    planes = 0;
    in_valid0 = 1'b1;
    wait_ready0();
    step();
    in_valid0 = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      step();
      if (wl_en0) begin
        seq = {seq[6:0], wl_bit0[0]};
        planes++;
      end
      if (out_valid0) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int               lat, planes, first_wl, first_acm, acm_cnt, seen, g;
    int               acc_cyc [3];
    logic [7:0]       seq;
    logic [ROWS*IN_BITS-1:0] vec [3];

    rstn = 1'b0; in_valid0 = 1'b0; in_valid2 = 1'b0;
    out_ready0 = 1'b1; out_ready2 = 1'b1; in_data = '0;
    for (int r = 0; r < ROWS; r++) w[r] = 1;
    repeat (3) step();
    checkOutput("rst_in_ready", 64'(in_ready0), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid0), 64'd0);
    checkOutput("rst_busy", 64'(busy0), 64'd0);
    checkOutput("rst_wl_en", 64'(wl_en0), 64'd0);
    checkOutput("rst_st", 64'(st0), 64'd0);
    checkOutput("rst_acm_en", 64'(acm_en0), 64'd0);
    checkOutput("rst_out_data", 64'(out_data0), 64'd0);
    rstn = 1'b1;
    step();
    step();
    checkOutput("idle_in_ready", 64'(in_ready0), 64'd1);
    checkOutput("idle_busy", 64'(busy0), 64'd0);

    $display("[TB] all-ones vector");
    for (int r = 0; r < ROWS; r++) in_data[r*IN_BITS +: IN_BITS] = 8'hFF;
    applyStimulus(lat, seq, planes);
    checkOutput("A_latency", 64'(lat), 64'd10);
    checkOutput("A_out_data", 64'(out_data0), 64'd16320);
    checkOutput("A_planes", 64'(planes), 64'd8);

    $display("[TB] single row 0xA5 weight 3");
    in_data = '0;
    in_data[7:0] = 8'hA5;
    w[0] = 3;
    applyStimulus(lat, seq, planes);
    checkOutput("B_latency", 64'(lat), 64'd10);
    checkOutput("B_wl_seq", 64'(seq), 64'hA5);
    checkOutput("B_out_data", 64'(out_data0), 64'd495);

    $display("[TB] reset mid-stream");
    in_valid0 = 1'b1;
    wait_ready0();
    step();
    in_valid0 = 1'b0;
    repeat (4) step();
    checkOutput("mid_busy", 64'(busy0), 64'd1);
    checkOutput("mid_wl_en", 64'(wl_en0), 64'd1);
    rstn = 1'b0;
    #1;
    checkOutput("abort_wl_en", 64'(wl_en0), 64'd0);
    checkOutput("abort_wl_bit", 64'(wl_bit0), 64'd0);
    checkOutput("abort_acm_en", 64'(acm_en0), 64'd0);
    checkOutput("abort_out_valid", 64'(out_valid0), 64'd0);
    checkOutput("abort_out_data", 64'(out_data0), 64'd0);
    checkOutput("abort_busy", 64'(busy0), 64'd0);
    checkOutput("abort_in_ready", 64'(in_ready0), 64'd0);
    step();
    rstn = 1'b1;
    step();
    step();
    checkOutput("abort_idle_ready", 64'(in_ready0), 64'd1);
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (out_valid0) seen = 1;
    end
    checkOutput("abort_no_result", 64'(seen), 64'd0);

    $display("[TB] array latency 2");
    in_valid2 = 1'b1;
    g = 0;
    while (!in_ready2 && g < 50) begin
      step();
      g++;
    end
    step();
    in_valid2 = 1'b0;
    lat = 0; first_wl = -1; first_acm = -1; acm_cnt = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (wl_en2 && first_wl < 0) first_wl = n;
      if (acm_en2) begin
        acm_cnt++;
        if (first_acm < 0) first_acm = n;
      end
      if (out_valid2) begin
        lat = n;
        break;
      end
    end
    checkOutput("C_latency", 64'(lat), 64'd12);
    checkOutput("C_out_data", 64'(out_data2), 64'd495);
    checkOutput("C_acm_count", 64'(acm_cnt), 64'd8);
    checkOutput("C_acm_offset", 64'(first_acm - first_wl), 64'd2);

    $display("[TB] output stall");
    out_ready0 = 1'b0;
    in_data = '0;
    in_data[7:0] = 8'd10;
    in_valid0 = 1'b1;
    wait_ready0();
    step();
    in_valid0 = 1'b0;
    g = 0;
    while (!out_valid0 && g < 30) begin
      step();
      g++;
    end
    checkOutput("D_first_valid", 64'(out_valid0), 64'd1);
    checkOutput("D_first_data", 64'(out_data0), 64'd30);
    in_data[7:0] = 8'd7;
    in_valid0 = 1'b1;
    wait_ready0();
    step();
    in_valid0 = 1'b0;
    repeat (15) step();
    checkOutput("D_stall_valid", 64'(out_valid0), 64'd1);
    checkOutput("D_stall_data", 64'(out_data0), 64'd30);
    checkOutput("D_stall_busy", 64'(busy0), 64'd1);
    checkOutput("D_stall_in_ready", 64'(in_ready0), 64'd0);
    res_q.delete();
    out_ready0 = 1'b1;
    step();
    checkOutput("D_second_valid", 64'(out_valid0), 64'd1);
    checkOutput("D_second_data", 64'(out_data0), 64'd21);
    step();
    checkOutput("D_drained_valid", 64'(out_valid0), 64'd0);
    checkOutput("D_order_count", 64'(res_q.size()), 64'd2);
    if (res_q.size() == 2) begin
      checkOutput("D_order_first", 64'(res_q[0]), 64'd30);
      checkOutput("D_order_second", 64'(res_q[1]), 64'd21);
    end

    $display("[TB] back-to-back vectors");
    vec[0] = '0; vec[0][7:0] = 8'd200;
    vec[1] = '0; vec[1][7:0] = 8'd1;
    vec[2] = '0; vec[2][7:0] = 8'd77; vec[2][63*IN_BITS +: IN_BITS] = 8'h80;
    repeat (2) step();
    res_q.delete();
    st_count0 = 0;
    in_valid0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = vec[i];
      wait_ready0();
      step();
      acc_cyc[i] = cyc;
    end
    in_valid0 = 1'b0;
    g = 0;
    while (res_q.size() < 3 && g < 40) begin
      step();
      g++;
    end
    checkOutput("E_count", 64'(res_q.size()), 64'd3);
    if (res_q.size() == 3) begin
      checkOutput("E_res0", 64'(res_q[0]), 64'd600);
      checkOutput("E_res1", 64'(res_q[1]), 64'd3);
      checkOutput("E_res2", 64'(res_q[2]), 64'd359);
    end
    checkOutput("E_st_pulses", 64'(st_count0), 64'd3);
    checkOutput("E_period01", 64'(acc_cyc[1] - acc_cyc[0]), 64'd11);
    checkOutput("E_period12", 64'(acc_cyc[2] - acc_cyc[1]), 64'd11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
